or_share_arbiter: RTL
=====================

# or_share_arbiter

Round-robin arbiter and data selector that shares one W-bit datapath among N requesters. It holds a registered one-hot grant for the duration of each requester's transaction and rotates priority on every release. It drives the shared datapath through an AND-OR select: each requester's data is masked by its grant bit and the masked rows are reduced with `or_rows`. It sits between requesting units, such as cache or bus masters, and a single shared resource port.

## Interface
Parameters:
- `N`, 4: number of requesters; must be ≥ 2.
- `W`, 32: width of each requester data word.
- `TIMEOUT`, 255: maximum busy cycles before forced release. Used only with `OR_SHARE_ARB_TIMEOUT_EN`; must be ≥ 1.

Ports:
- `clk`  in  1  sole clock; rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `Req`  in  N  per-requester request level.
- `Done`  in  N  per-requester end-of-transaction pulse; sampled only for the current owner.
- `ReqData`  in  N×W  unpacked array `[N-1:0]` of per-requester data words.
- `Grant`  out  N  registered one-hot grant, or all-zero.
- `GrantValid`  out  1  `|Grant`.
- `Owner`  out  $clog2(N)  index of the granted requester; 0 when idle.
- `BusData`  out  W  OR over all rows of `ReqData[i] & {W{Grant[i]}}`; combinational from `Grant`.
- `TimeoutErr`  out  1  one-cycle pulse on forced release.

## Operation
- State: IDLE or BUSY, plus `Ptr`, a $clog2(N)-bit rotating priority pointer.
- IDLE, any `Req` set:
  - Grant the first set `Req` bit searching `Ptr`, `Ptr+1`, … mod N.
  - Enter BUSY on the next edge.
- IDLE, no `Req`: remain in IDLE; `Grant` = 0.
- BUSY: `Grant` is held unchanged regardless of `Req`; the owner dropping `Req` does not release.
- Release occurs on `Done[Owner]` = 1 in BUSY. On release:
  - `Ptr` ← (`Owner` + 1) mod N.
  - The arbitration result is computed with the new `Ptr`, excluding the releasing owner's request that cycle.
  - If another `Req` is set, the new grant loads on the same edge, with no bubble.
  - Otherwise the block returns to IDLE with `Grant` = 0.
- Ignored inputs:
  - `Done` bits of non-owners.
  - Any `Done` while in IDLE.
- Pointer wrap: `Owner` = N-1 sets `Ptr` = 0.
- `BusData` is 0 whenever `Grant` = 0. `Grant` is never multi-hot, so at most one row is non-zero.
- Reset mid-transaction immediately clears the grant: `Grant`, `Ptr`, `Owner`, `GrantValid` and `TimeoutErr` all go to 0, and the state returns to IDLE.
- Reset values of all outputs are 0.

## Timing
- Request-to-grant latency from IDLE is 1 cycle: `Req` is sampled at edge k and `Grant` is valid after edge k.
- Release-to-next-grant latency is 0 extra cycles: `Done` is sampled at edge k and the new `Grant` is valid after edge k.
- `BusData` follows `Grant` combinationally within the same cycle, with no register.
- `TimeoutErr` is high for exactly the one cycle following the forced-release edge.

## Configuration
- Macro: `OR_SHARE_ARB_TIMEOUT_EN`.
- Defined:
  - A busy counter clears on each new grant and increments each BUSY cycle without `Done[Owner]`.
  - When the counter reaches `TIMEOUT`, the block performs a release exactly as if `Done[Owner]` were asserted.
  - `TimeoutErr` pulses.
  - `Done[Owner]` on the same cycle takes precedence, giving a normal release with no `TimeoutErr`.
- Undefined:
  - No counter is built.
  - `TimeoutErr` is tied to 0.
  - The owner holds the grant indefinitely until `Done`.

## Test plan
- Reset: assert `reset_n` = 0 asynchronously mid-cycle while `Grant` = 0b0100 → all outputs read 0 immediately. After release with `Req` = 0b0001, `Grant` = 0b0001 one edge later.
- Basic grant and hand-off, N=4: `Req` = 0b0110 from IDLE → `Grant` = 0b0010, `Owner` = 1. Then pulse `Done[1]` → `Grant` = 0b0100 on the same edge, `Ptr` = 2.
- Fairness: hold `Req` = 0b1111 and pulse `Done[Owner]` every cycle → `Grant` sequence 0001, 0010, 0100, 1000, 0001 (wrap).
- Data select, W=32: `ReqData[2]` = 0xA5A50000 and others 0xFFFFFFFF, with `Grant` = 0b0100 → `BusData` = 0xA5A50000. With `Grant` = 0 → `BusData` = 0.
- Ignored inputs: with owner 0, pulse `Done[3]` and drop `Req[0]` → `Grant` stays 0b0001. `Done` while IDLE → no state change.
- Timeout, macro defined, `TIMEOUT` = 8: owner 0 never asserts `Done`, `Req` = 0b0011 → `Grant` moves to 0b0010 after 8 busy cycles and `TimeoutErr` pulses once. With the macro undefined, `Grant` remains 0b0001 for 100+ cycles.

Source files
------------

// File: rtl/or_share_arbiter.sv
// Round-robin arbiter with a registered one-hot grant that is held for a whole
// transaction, plus an AND-OR data selector onto one shared W-bit bus.
// Optional forced release after TIMEOUT busy cycles: define OR_SHARE_ARB_TIMEOUT_EN.
module or_share_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         Req,
  input  logic [N-1:0]         Done,
  input  logic [W-1:0]         ReqData [N-1:0],
  output logic [N-1:0]         Grant,
  output logic                 GrantValid,
  output logic [$clog2(N)-1:0] Owner,
  output logic [W-1:0]         BusData,
  output logic                 TimeoutErr
);

  localparam int unsigned IdxW = $clog2(N);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  // Elaboration-time parameter sanity checks.
  if (N < 2) begin : g_bad_n
    $error("or_share_arbiter: N must be >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("or_share_arbiter: TIMEOUT must be >= 1");
  end

  // OR-reduce a set of already-masked rows.
  function automatic logic [W-1:0] or_rows(input logic [W-1:0] rows [N-1:0]);
    logic [W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < N; i++) begin
      acc = acc | rows[i];
    end
    return acc;
  endfunction

  logic [0:0]      state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] ptr_q, ptr_d;

  logic            busy;
  logic            owner_done;
  logic            timeout_hit;
  logic            release_now;
  logic            load_grant;
  logic [IdxW-1:0] next_idx;
  logic [IdxW-1:0] start_idx;
  logic [N-1:0]    cand;
  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;
  int unsigned     scan_idx;
  logic [W-1:0]    masked [N-1:0];

  assign busy       = (state_q == StBusy);
  assign owner_done = Done[owner_q];
  // A forced release behaves exactly like Done from the owner.
  assign release_now = busy && (owner_done || timeout_hit);
  assign next_idx    = (owner_q == IdxW'(N - 1)) ? '0 : owner_q + IdxW'(1);
  // Arbitrate from the post-release pointer so hand-off needs no idle cycle.
  assign start_idx   = release_now ? next_idx : ptr_q;
  assign load_grant  = pick_valid && (!busy || release_now);

  // Candidate set: the releasing owner is excluded for the hand-off cycle.
  always_comb begin
    cand = Req;
    if (release_now) begin
      cand[owner_q] = 1'b0;
    end
  end

  // First set candidate searching start_idx, start_idx+1, ... mod N.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = 32'(start_idx) + k;
      if (scan_idx >= N) begin
        scan_idx = scan_idx - N;
      end
      if (!pick_valid && cand[scan_idx[IdxW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx[IdxW-1:0];
      end
    end
  end

  // Next-state: grant from IDLE, hold in BUSY, hand off or go idle on release.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StBusy;
          grant_d = N'(1) << pick_idx;
          owner_d = pick_idx;
        end
      end
      default: begin
        if (release_now) begin
          ptr_d = next_idx;
          if (pick_valid) begin
            grant_d = N'(1) << pick_idx;
            owner_d = pick_idx;
          end else begin
            state_d = StIdle;
            grant_d = '0;
            owner_d = '0;
          end
        end
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef OR_SHARE_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q;

  assign timeout_hit = busy && !owner_done && (cnt_q == CntW'(TIMEOUT - 1));

  // Busy counter: restarts with every grant or release, counts Done-less busy cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (load_grant || release_now) begin
      cnt_d = '0;
    end else if (busy && !owner_done) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter and one-cycle error pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout_hit;
    end
  end

  assign TimeoutErr = err_q;
`else
  assign timeout_hit = 1'b0;
  assign TimeoutErr  = 1'b0;
`endif

  // AND-OR select: only the granted row survives the mask.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      masked[i] = ReqData[i] & {W{grant_q[i]}};
    end
  end

  assign BusData    = or_rows(masked);
  assign Grant      = grant_q;
  assign GrantValid = |grant_q;
  assign Owner      = owner_q;

endmodule
